// File: rtl/tx_frame_arbiter.sv
// Round-robin arbiter that shares one serial byte transmitter between N_REQ requesters,
// launching each frame with a one-cycle VALID and counting it out before re-arbitrating.
module tx_frame_arbiter #(
  parameter int unsigned N_REQ = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic [N_REQ-1:0]     REQ,
  input  logic [8*N_REQ-1:0]   REQ_DATA,
  input  logic [2*N_REQ-1:0]   REQ_PMODE,
  output logic [N_REQ-1:0]     GNT,
  output logic                 VALID,
  output logic [7:0]           DATA_IN,
  output logic [1:0]           PARITY_MODE,
  output logic                 BUSY,
  output logic [2:0]           OWNER,
  output logic                 FRAME_DONE
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2
  } state_t;

  state_t      state;
  logic [2:0]  last;
  logic [3:0]  fcnt;
  int unsigned cand;
  int unsigned win_idx;

  // Scanning offsets from farthest to nearest lets the nearest set bit after `last` win.
  always_comb begin
    cand    = 0;
    win_idx = 0;
    for (int unsigned k = N_REQ; k >= 1; k--) begin
      cand = (32'(last) + k) % N_REQ;
      if (|(REQ & (N_REQ'(1) << cand)))
        win_idx = cand;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state       <= S_IDLE;
      last        <= 3'(N_REQ - 1);
      fcnt        <= '0;
      GNT         <= '0;
      VALID       <= 1'b0;
      DATA_IN     <= '0;
      PARITY_MODE <= '0;
      BUSY        <= 1'b0;
      OWNER       <= '0;
      FRAME_DONE  <= 1'b0;
    end else begin
      FRAME_DONE <= 1'b0;
      case (state)
        S_IDLE: begin
          if (|REQ) begin
            GNT         <= N_REQ'(1) << win_idx;
            VALID       <= 1'b1;
            DATA_IN     <= 8'(REQ_DATA >> (8 * win_idx));
            PARITY_MODE <= 2'(REQ_PMODE >> (2 * win_idx));
            OWNER       <= 3'(win_idx);
            last        <= 3'(win_idx);
            BUSY        <= 1'b1;
            state       <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          // Mode 11 counts as no parity, giving the short frame.
          fcnt  <= (PARITY_MODE == 2'b01 || PARITY_MODE == 2'b10) ? 4'd9 : 4'd8;
          GNT   <= '0;
          VALID <= 1'b0;
          state <= S_WAIT;
        end
        S_WAIT: begin
          fcnt <= fcnt - 4'd1;
          if (fcnt == 4'd1) begin
            FRAME_DONE <= 1'b1;
            BUSY       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_frame_arbiter.sv
// Scoreboard bench for tx_frame_arbiter: stimulus pushes expected grants and frame
// lengths, a negedge monitor pops and compares them when VALID / FRAME_DONE appear.
module tb_tx_frame_arbiter;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic [3:0]  REQ;
  logic [31:0] REQ_DATA;
  logic [7:0]  REQ_PMODE;
  logic [3:0]  GNT;
  logic        VALID;
  logic [7:0]  DATA_IN;
  logic [1:0]  PARITY_MODE;
  logic        BUSY;
  logic [2:0]  OWNER;
  logic        FRAME_DONE;

  logic [7:0] d  [4];
  logic [1:0] pm [4];

  assign REQ_DATA  = {d[3], d[2], d[1], d[0]};
  assign REQ_PMODE = {pm[3], pm[2], pm[1], pm[0]};

  tx_frame_arbiter #(.N_REQ(4)) dut (
    .CLK(CLK), .RST_N(RST_N), .REQ(REQ), .REQ_DATA(REQ_DATA), .REQ_PMODE(REQ_PMODE),
    .GNT(GNT), .VALID(VALID), .DATA_IN(DATA_IN), .PARITY_MODE(PARITY_MODE),
    .BUSY(BUSY), .OWNER(OWNER), .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [3:0] gnt;
    logic [7:0] data;
    logic [1:0] pm;
    logic [2:0] owner;
    int         gap;
  } exp_t;

  exp_t exp_q[$];
  int   done_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int unsigned act, input int unsigned req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic exp_grant(input int idx, input logic [7:0] data, input logic [1:0] pmode,
                           input int gap, input int dlen);
    exp_t e;
    e.gnt   = 4'b0001 << idx;
    e.data  = data;
    e.pm    = pmode;
    e.owner = 3'(idx);
    e.gap   = gap;
    exp_q.push_back(e);
    done_q.push_back(dlen);
  endtask

  // Monitor
  int         cycle = 0;
  int         last_vcycle = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] hold_data = '0;
  logic [1:0] hold_pm = '0;

  initial begin
    exp_t e;
    int   dl;
    forever begin
      @(negedge CLK);
      cycle++;
      if (RST_N) begin
        if (GNT != 4'b0000 && !VALID) check("gnt_without_valid", 32'(GNT), 0);
        if (VALID && prev_valid)      check("valid_consecutive", 1, 0);
        if (VALID) begin
          if (exp_q.size() == 0) begin
            check("unexpected_grant", 32'(GNT), 0);
          end else begin
            e = exp_q.pop_front();
            check("gnt",         32'(GNT),         32'(e.gnt));
            check("data_in",     32'(DATA_IN),     32'(e.data));
            check("parity_mode", 32'(PARITY_MODE), 32'(e.pm));
            check("owner",       32'(OWNER),       32'(e.owner));
            check("busy_launch", 32'(BUSY),        1);
            if (e.gap != 0) check("valid_spacing", cycle - last_vcycle, e.gap);
          end
          last_vcycle = cycle;
          hold_data   = DATA_IN;
          hold_pm     = PARITY_MODE;
        end else if (BUSY) begin
          check("data_stable", 32'(DATA_IN),     32'(hold_data));
          check("pmode_stable", 32'(PARITY_MODE), 32'(hold_pm));
        end
        if (FRAME_DONE) begin
          if (done_q.size() == 0) begin
            check("unexpected_frame_done", 1, 0);
          end else begin
            dl = done_q.pop_front();
            check("frame_len", cycle - last_vcycle, dl);
            check("busy_at_done", 32'(BUSY), 0);
          end
        end
      end
      prev_valid = RST_N ? VALID : 1'b0;
    end
  end

  task automatic wait_gnt(input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (GNT != 4'b0000) return;
    end
    check({name, "_gnt_timeout"}, 1, 0);
  endtask

  task automatic wait_done(input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge CLK);
      if (FRAME_DONE) return;
    end
    check({name, "_done_timeout"}, 1, 0);
  endtask

  task automatic grants_then_drop(input string name, input int n);
    for (int i = 0; i < n; i++) wait_gnt(name);
    REQ = 4'b0000;
    wait_done(name);
    repeat (2) @(negedge CLK);
  endtask

  task automatic do_reset();
    RST_N = 1'b0;
    repeat (2) @(negedge CLK);
    exp_q.delete();
    done_q.delete();
    RST_N = 1'b1;
    @(negedge CLK);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST_N = 1'b0;
    REQ   = 4'b0000;
    for (int i = 0; i < 4; i++) begin d[i] = '0; pm[i] = '0; end
    repeat (2) @(negedge CLK);
    check("rst_gnt",   32'(GNT), 0);
    check("rst_valid", 32'(VALID), 0);
    check("rst_data",  32'(DATA_IN), 0);
    check("rst_pm",    32'(PARITY_MODE), 0);
    check("rst_busy",  32'(BUSY), 0);
    check("rst_owner", 32'(OWNER), 0);
    check("rst_done",  32'(FRAME_DONE), 0);
    RST_N = 1'b1;
    @(negedge CLK);

    // single request, odd parity
    d[0] = 8'hA5; pm[0] = 2'b01;
    exp_grant(0, 8'hA5, 2'b01, 0, 10);
    REQ = 4'b0001;
    grants_then_drop("single", 1);

    // round robin from reset, even parity
    do_reset();
    d[0] = 8'h11; d[1] = 8'h22; d[2] = 8'h33; d[3] = 8'h44;
    for (int i = 0; i < 4; i++) pm[i] = 2'b10;
    exp_grant(0, 8'h11, 2'b10, 0, 10);
    exp_grant(1, 8'h22, 2'b10, 11, 10);
    exp_grant(2, 8'h33, 2'b10, 11, 10);
    exp_grant(3, 8'h44, 2'b10, 11, 10);
    exp_grant(0, 8'h11, 2'b10, 11, 10);
    REQ = 4'b1111;
    grants_then_drop("rr_even", 5);

    // round robin, no parity; pointer at 0
    for (int i = 0; i < 4; i++) pm[i] = 2'b00;
    exp_grant(1, 8'h22, 2'b00, 0, 9);
    exp_grant(2, 8'h33, 2'b00, 10, 9);
    exp_grant(3, 8'h44, 2'b00, 10, 9);
    exp_grant(0, 8'h11, 2'b00, 10, 9);
    REQ = 4'b1111;
    grants_then_drop("rr_none", 4);

    // move pointer to 2, then wrap to 0 and 1
    d[2] = 8'h5A;
    exp_grant(2, 8'h5A, 2'b00, 0, 9);
    REQ = 4'b0100;
    grants_then_drop("ptr2", 1);
    d[0] = 8'h66; pm[0] = 2'b00; d[1] = 8'h77; pm[1] = 2'b01;
    exp_grant(0, 8'h66, 2'b00, 0, 9);
    exp_grant(1, 8'h77, 2'b01, 10, 10);
    REQ = 4'b0011;
    grants_then_drop("wrap", 2);

    // lone requester 3 granted twice
    d[3] = 8'h88; pm[3] = 2'b10;
    exp_grant(3, 8'h88, 2'b10, 0, 10);
    exp_grant(3, 8'h88, 2'b10, 11, 10);
    REQ = 4'b1000;
    grants_then_drop("skip", 2);

    // mixed modes: 11 behaves as no parity
    d[0] = 8'h99; pm[0] = 2'b11; d[1] = 8'hC3; pm[1] = 2'b01;
    exp_grant(0, 8'h99, 2'b11, 0, 9);
    exp_grant(1, 8'hC3, 2'b01, 10, 10);
    REQ = 4'b0011;
    grants_then_drop("mixed", 2);

    // withdrawal of requester 2 during WAIT
    d[0] = 8'h3C; pm[0] = 2'b00;
    exp_grant(0, 8'h3C, 2'b00, 0, 9);
    REQ = 4'b0001;
    wait_gnt("withdraw");
    REQ = 4'b0000;
    repeat (2) @(negedge CLK);
    REQ[2] = 1'b1;
    repeat (3) @(negedge CLK);
    REQ[2] = 1'b0;
    wait_done("withdraw");
    repeat (4) @(negedge CLK);
    check("withdraw_busy", 32'(BUSY), 0);
    check("withdraw_gnt",  32'(GNT), 0);

    // reset mid-frame
    exp_grant(1, 8'hC3, 2'b01, 0, 10);
    REQ = 4'b0010;
    wait_gnt("midrst");
    REQ = 4'b0000;
    repeat (3) @(negedge CLK);
    @(posedge CLK);
    #1 RST_N = 1'b0;
    #1;
    check("midrst_gnt",   32'(GNT), 0);
    check("midrst_valid", 32'(VALID), 0);
    check("midrst_data",  32'(DATA_IN), 0);
    check("midrst_pm",    32'(PARITY_MODE), 0);
    check("midrst_busy",  32'(BUSY), 0);
    check("midrst_owner", 32'(OWNER), 0);
    check("midrst_done",  32'(FRAME_DONE), 0);
    exp_q.delete();
    done_q.delete();
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (12) @(negedge CLK);
    exp_grant(0, 8'h3C, 2'b00, 0, 9);
    REQ = 4'b1111;
    grants_then_drop("post_rst", 1);

    check("exp_q_empty",  exp_q.size(), 0);
    check("done_q_empty", done_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tx_frame_arbiter.md
# tx_frame_arbiter

Round-robin arbiter and sequencer that shares the single parity-capable serial byte transmitter between `N_REQ` requesters. It selects one pending requester and captures that requester's byte and parity mode. It then issues a single-cycle `VALID` launch to the transmitter and holds the transmitter inputs stable while it counts out the frame. It reports completion so the next frame launches as soon as the transmitter is back in its idle state.

## Interface
- `N_REQ`, default 4: number of requesters; range 2..8.
- `CLK`  in  1  sole clock; all logic on rising edge.
- `RST_N`  in  1  reset, asynchronous and active-low.
- `REQ`  in  N_REQ  per-requester request; held high with data stable until `GNT`.
- `REQ_DATA`  in  8*N_REQ  byte of requester i at [8i+7:8i].
- `REQ_PMODE`  in  2*N_REQ  parity mode of requester i at [2i+1:2i]; 01 = odd, 10 = even, 00/11 = none.
- `GNT`  out  N_REQ  one-hot, one-cycle acknowledge; requester's byte has been captured.
- `VALID`  out  1  one-cycle launch strobe to transmitter.
- `DATA_IN`  out  8  byte to transmitter.
- `PARITY_MODE`  out  2  parity mode to transmitter; stable for the whole frame.
- `BUSY`  out  1  high while a frame is launched or in flight.
- `OWNER`  out  3  index of the current or last granted requester.
- `FRAME_DONE`  out  1  one-cycle pulse when the transmitter has returned to idle.

## Operation
- All outputs are registered.
- Reset values: `GNT`=0, `VALID`=0, `DATA_IN`=0, `PARITY_MODE`=00, `BUSY`=0, `OWNER`=0, `FRAME_DONE`=0, state IDLE, round-robin pointer `last`=N_REQ-1.
- States: IDLE, LAUNCH, WAIT.
- **IDLE**
  - If any `REQ` bit is set, pick the first set bit searching from `last`+1 upward, wrapping modulo N_REQ.
  - Register the winner's `DATA_IN`/`PARITY_MODE`; set `GNT[win]`=1, `VALID`=1, `OWNER`=win, `last`=win, `BUSY`=1; go to LAUNCH.
  - Otherwise stay in IDLE.
- **LAUNCH** (one cycle, `GNT` and `VALID` high)
  - Load frame counter `fcnt` = 9 if parity mode is 01/10, else 8.
  - Clear `GNT` and `VALID`; go to WAIT.
- **WAIT**
  - Decrement `fcnt`; `REQ` is ignored.
  - When `fcnt`==1: set `FRAME_DONE`=1, `BUSY`=0; go to IDLE.
- In the IDLE cycle where `FRAME_DONE` is high, arbitration is already live, so a pending request is granted in that cycle.
- `DATA_IN`/`PARITY_MODE` hold their values until the next grant; they never change between grants.
- Parity mode 11 is treated exactly as 00: no parity, short frame.
- A `REQ` that drops before it is granted is forgotten; no grant is issued for it.
- `REQ` changes during LAUNCH/WAIT have no effect; sampling resumes in IDLE.
- Reset mid-frame: everything returns to its reset value immediately. No `FRAME_DONE` is issued for the aborted frame. The transmitter is reset by the same `RST_N`.

## Timing
- Grant latency: `REQ` seen high in IDLE at cycle c → `GNT`/`VALID` high in cycle c+1; the transmitter accepts at the end of c+1.
- Parity frame: `FRAME_DONE` in c+11. No-parity frame: `FRAME_DONE` in c+10.
- Back-to-back: with `REQ` continuously pending, consecutive `VALID` pulses are exactly 11 cycles apart (parity) or 10 (no parity). No idle gap is permitted beyond that.
- `BUSY` is high from c+1 through the cycle before `FRAME_DONE`.
- `VALID` is never high for two consecutive cycles.
- `VALID` is never issued while the transmitter is outside its idle state.

## Test plan
- Single request: reset, then `REQ`=0001, byte 0xA5, pmode 01 → `GNT`=0001 and `VALID` one cycle later with `DATA_IN`=0xA5, `PARITY_MODE`=01. The transmitter serializes 1,0,1,0,0,1,0,1, then parity 1. `FRAME_DONE` arrives 11 cycles after the request.
- Round-robin fairness: `REQ`=1111 held with bytes 0x11/0x22/0x33/0x44 → grants in order 0,1,2,3,0. `OWNER` follows the same sequence. `VALID` spacing is 11 with pmode 10, or 10 with pmode 00.
- Pointer wrap and skip: `last`=2, `REQ`=0011 → requester 0 is granted, then 1. `REQ`=1000 alone → requester 3 is granted, then 3 again.
- Mixed modes: requester 0 with pmode 11 then requester 1 with pmode 01 → the first frame has no parity bit and `FRAME_DONE` comes 10 cycles after its request. The second frame's `PARITY_MODE` stays 01 through its parity bit.
- Request withdrawal: requester 2 raises `REQ` during WAIT, then drops it before `FRAME_DONE` → no `GNT[2]`; the arbiter stays IDLE and `BUSY`=0.
- Reset mid-frame: assert `RST_N`=0 at cycle 5 of a frame → all outputs are 0 asynchronously and no `FRAME_DONE` is issued. After release, the next grant goes to requester 0 first.
